// File: rtl/sprite_attr_ram_if.sv
// Bus bundle between the sprite register decoder (write side), the line renderer (read side) and the RAM.
// Covers the clear request and busy flag, the byte-enabled write port, and the read port.
interface sprite_attr_ram_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   localparam int NB = DATA_W / 8;

   logic              clr_i;
   logic              busy_o;
   logic              wr_en_i;
   logic [NB-1:0]     ben_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              rd_en_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              rd_valid_o;

   modport master (
      output clr_i, wr_en_i, ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      input  busy_o, rd_data_o, rd_valid_o
   );

   modport slave (
      input  clr_i, wr_en_i, ben_i, wr_addr_i, wr_data_i, rd_en_i, rd_addr_i,
      output busy_o, rd_data_o, rd_valid_o
   );
endinterface

// File: rtl/sprite_attr_ram.sv
// Sprite attribute RAM: byte-enabled write, write-first read with RD_LATENCY (1 or 2) cycles, no backpressure.
// A clear engine zeroes every entry after reset and on clr_i; writes are dropped and reads return 0 while it runs.
module sprite_attr_ram #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int RD_LATENCY     = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   sprite_attr_ram_if.slave   bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
   localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, busy_d;
   logic              rd_vld1_q, rd_vld1_d;
   logic [DATA_W-1:0] rd_dat1_q, rd_dat1_d;
   logic [DATA_W-1:0] rd_merged;
   logic              clearing;

   // Not reset on purpose: only the sweep zeroes it, so it stays a plain block RAM.
   logic [DATA_W-1:0] mem [DEPTH];

   assign clearing = (state_q == ST_CLEAR);

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (clearing) begin
         clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         if (clr_cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
         end
      end else if (bus.clr_i) begin
         state_d   = ST_CLEAR;
         clr_cnt_d = '0;
      end
      busy_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge clk_i) begin
      if (clearing) begin
         mem[clr_cnt_q] <= '0;
      end else if (bus.wr_en_i) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.ben_i[k]) begin
               mem[bus.wr_addr_i][8*k +: 8] <= bus.wr_data_i[8*k +: 8];
            end
         end
      end
   end

   // Write-first bypass: enabled lanes of a same-address write override the stored word.
   always_comb begin
      rd_merged = mem[bus.rd_addr_i];
      if (clearing) begin
         rd_merged = '0;
      end else if (bus.wr_en_i && (bus.wr_addr_i == bus.rd_addr_i)) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.ben_i[k]) begin
               rd_merged[8*k +: 8] = bus.wr_data_i[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_vld1_d = bus.rd_en_i;
      rd_dat1_d = bus.rd_en_i ? rd_merged : rd_dat1_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_RESET;
         clr_cnt_q <= '0;
         busy_q    <= (CLEAR_ON_RESET != 0);
         rd_vld1_q <= 1'b0;
         rd_dat1_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
         rd_vld1_q <= rd_vld1_d;
         rd_dat1_q <= rd_dat1_d;
      end
   end

   assign bus.busy_o = busy_q;

   generate
      if (RD_LATENCY == 2) begin : gen_lat2
         logic              rd_vld2_q, rd_vld2_d;
         logic [DATA_W-1:0] rd_dat2_q, rd_dat2_d;

         always_comb begin
            rd_vld2_d = rd_vld1_q;
            rd_dat2_d = rd_vld1_q ? rd_dat1_q : rd_dat2_q;
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               rd_vld2_q <= 1'b0;
               rd_dat2_q <= '0;
            end else begin
               rd_vld2_q <= rd_vld2_d;
               rd_dat2_q <= rd_dat2_d;
            end
         end

         assign bus.rd_valid_o = rd_vld2_q;
         assign bus.rd_data_o  = rd_dat2_q;
      end else begin : gen_lat1
         assign bus.rd_valid_o = rd_vld1_q;
         assign bus.rd_data_o  = rd_dat1_q;
      end
   endgenerate
endmodule

// File: tb/tb_sprite_attr_ram.sv
// Scoreboarded bench: two RAMs (read latency 1 and 2) driven with identical directed stimulus.
module tb_sprite_attr_ram;
   localparam int AW = 8;
   localparam int DW = 32;

   typedef struct {
      logic [31:0] dat;
      int          due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   sprite_attr_ram_if #(.ADDR_W(AW), .DATA_W(DW)) sif1 ();
   sprite_attr_ram_if #(.ADDR_W(AW), .DATA_W(DW)) sif2 ();

   sprite_attr_ram #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (sif1)
   );

   sprite_attr_ram #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (sif2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic set_in(input logic clr, input logic we, input logic [3:0] be, input logic [7:0] wa,
                         input logic [31:0] wd, input logic re, input logic [7:0] ra);
      sif1.clr_i = clr; sif1.wr_en_i = we; sif1.ben_i = be; sif1.wr_addr_i = wa;
      sif1.wr_data_i = wd; sif1.rd_en_i = re; sif1.rd_addr_i = ra;
      sif2.clr_i = clr; sif2.wr_en_i = we; sif2.ben_i = be; sif2.wr_addr_i = wa;
      sif2.wr_data_i = wd; sif2.rd_en_i = re; sif2.rd_addr_i = ra;
   endtask

   // One cycle of stimulus, called at a falling edge; any read pushes its hand-computed result.
   task automatic op(input logic we, input logic [3:0] be, input logic [7:0] wa, input logic [31:0] wd,
                     input logic re, input logic [7:0] ra, input logic [31:0] rexp);
      exp_t e;
      set_in(1'b0, we, be, wa, wd, re, ra);
      if (re) begin
         e.dat = rexp;
         e.due = cyc + 1;
         q1.push_back(e);
         e.due = cyc + 2;
         q2.push_back(e);
      end
      @(negedge clk);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] ra, input logic [31:0] rexp);
      op(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, ra, rexp);
   endtask

   task automatic wr(input logic [3:0] be, input logic [7:0] wa, input logic [31:0] wd);
      op(1'b1, be, wa, wd, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic wait_cyc(input int target);
      int g = 0;
      while (cyc < target && g < 2000) begin
         @(negedge clk);
         g++;
      end
   endtask

   // Counts cycles from now until busy_o falls on both instances.
   task automatic wait_sweep(input string name, input int start);
      int g = 0;
      while ((sif1.busy_o || sif2.busy_o) && g < 1000) begin
         @(negedge clk);
         g++;
      end
      chk(name, 32'(cyc - start), 32'd256);
   endtask

   initial begin : mon1
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sif1.rd_valid_o) begin
            if (q1.size() == 0) begin
               chk("lat1_spurious_valid", 32'(sif1.rd_valid_o), 32'd0);
            end else begin
               e = q1.pop_front();
               chk("lat1_data", sif1.rd_data_o, e.dat);
               chk("lat1_cycle", 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   initial begin : mon2
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && sif2.rd_valid_o) begin
            if (q2.size() == 0) begin
               chk("lat2_spurious_valid", 32'(sif2.rd_valid_o), 32'd0);
            end else begin
               e = q2.pop_front();
               chk("lat2_data", sif2.rd_data_o, e.dat);
               chk("lat2_cycle", 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1);
   end

   initial begin : stim
      int t0;
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      repeat (3) @(negedge clk);

      chk("rst_busy1", 32'(sif1.busy_o), 32'd1);
      chk("rst_busy2", 32'(sif2.busy_o), 32'd1);
      chk("rst_rd_valid1", 32'(sif1.rd_valid_o), 32'd0);
      chk("rst_rd_valid2", 32'(sif2.rd_valid_o), 32'd0);
      chk("rst_rd_data1", sif1.rd_data_o, 32'h0);
      chk("rst_rd_data2", sif2.rd_data_o, 32'h0);

      rst_n = 1'b1;
      t0 = cyc;
      wait_sweep("reset_sweep_len", t0);
      rd(8'd0, 32'h0);
      rd(8'd128, 32'h0);
      rd(8'd255, 32'h0);

      // Byte-enable merge, then a ben=0 write that must not touch the word.
      wr(4'hF, 8'd5, 32'hAABBCCDD);
      wr(4'h5, 8'd5, 32'h11223344);
      op(1'b1, 4'h0, 8'd5, 32'hFFFFFFFF, 1'b1, 8'd5, 32'hAA22CC44);
      rd(8'd5, 32'hAA22CC44);

      // Same-cycle read/write is write-first per lane.
      wr(4'hF, 8'd7, 32'h12345678);
      op(1'b1, 4'h3, 8'd7, 32'h0000BEEF, 1'b1, 8'd7, 32'h1234BEEF);
      rd(8'd7, 32'h1234BEEF);

      // Back-to-back streaming reads.
      wr(4'hF, 8'd0, 32'hCAFEF00D);
      wr(4'hF, 8'd1, 32'h01010101);
      wr(4'hF, 8'd2, 32'h02020202);
      op(1'b1, 4'hF, 8'd3, 32'h03030303, 1'b1, 8'd1, 32'h01010101);
      rd(8'd2, 32'h02020202);
      rd(8'd3, 32'h03030303);
      rd(8'd0, 32'hCAFEF00D);
      repeat (4) @(negedge clk);

      // Clear request with traffic during the sweep.
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      @(negedge clk);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      t0 = cyc;
      chk("clr_busy_rise", 32'(sif1.busy_o), 32'd1);
      repeat (10) @(negedge clk);
      op(1'b1, 4'hF, 8'd2, 32'hFFFFFFFF, 1'b1, 8'd2, 32'h0);
      rd(8'd3, 32'h0);
      rd(8'd200, 32'h0);
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      @(negedge clk);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      wait_cyc(t0 + 255);
      chk("clr_busy_last_cycle", 32'(sif1.busy_o), 32'd1);
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      @(negedge clk);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      chk("clr_sweep_len", 32'(cyc - t0), 32'd256);
      chk("clr_busy_fall1", 32'(sif1.busy_o), 32'd0);
      chk("clr_busy_fall2", 32'(sif2.busy_o), 32'd0);
      @(negedge clk);
      chk("clr_final_req_ignored", 32'(sif1.busy_o), 32'd0);
      rd(8'd0, 32'h0);
      rd(8'd1, 32'h0);
      rd(8'd2, 32'h0);
      rd(8'd3, 32'h0);
      rd(8'd7, 32'h0);
      repeat (4) @(negedge clk);

      // Reset asserted mid-sweep with a read in flight.
      set_in(1'b1, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      @(negedge clk);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      t0 = cyc;
      wait_cyc(t0 + 99);
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'd50);
      @(posedge clk);
      #1;
      set_in(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
      chk("midrst_valid_before", 32'(sif1.rd_valid_o), 32'd1);
      rst_n = 1'b0;
      q1.delete();
      q2.delete();
      #1;
      chk("midrst_rd_valid1", 32'(sif1.rd_valid_o), 32'd0);
      chk("midrst_rd_valid2", 32'(sif2.rd_valid_o), 32'd0);
      chk("midrst_busy1", 32'(sif1.busy_o), 32'd1);
      chk("midrst_busy2", 32'(sif2.busy_o), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t0 = cyc;
      wait_sweep("midrst_sweep_len", t0);
      rd(8'd5, 32'h0);
      rd(8'd255, 32'h0);
      repeat (5) @(negedge clk);

      chk("lat1_queue_drained", 32'(q1.size()), 32'd0);
      chk("lat2_queue_drained", 32'(q2.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sprite_attr_ram.md
# sprite_attr_ram

Parametrised, single-clock sprite attribute RAM for the VERA sprite renderer. One write port with per-byte enables and one read port with configurable read latency. A hardware clear engine zeroes every entry after reset and on request, so the renderer never fetches stale attributes. Sits between the bus-side sprite register decoder (write port) and the sprite line renderer (read port).

## Interface
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W entries.
- DATA_W, 32: word width; must be a multiple of 8; NB = DATA_W/8 byte lanes.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep automatically after reset; 0 = contents undefined until the first clr_i.
- clk_i  in  1  single clock for all logic.
- rst_ni  in  1  asynchronous, active-low reset.
- clr_i  in  1  single-cycle request to zero all entries.
- busy_o  out  1  high while the clear sweep is running.
- wr_en_i  in  1  write strobe.
- ben_i  in  NB  byte-lane enables; bit k covers data bits [8k+7:8k].
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  ADDR_W  read address.
- rd_data_o  out  DATA_W  read data.
- rd_valid_o  out  1  rd_data_o carries the result of a read issued RD_LATENCY cycles earlier.

## Operation
- FSM with two states, IDLE and CLEAR. A counter clr_cnt (ADDR_W bits) drives the sweep.
- CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. When clr_cnt == DEPTH-1, the FSM writes that last entry and moves to IDLE. The sweep lasts exactly DEPTH cycles.
- IDLE + clr_i: enter CLEAR with clr_cnt = 0 on the next edge.
- clr_i in CLEAR: ignored. The sweep does not restart.
- Writes in IDLE: for each k with ben_i[k]=1, mem[wr_addr_i] lane k <= wr_data_i lane k. Lanes with ben_i[k]=0 keep their value. wr_en_i with ben_i = 0 is a no-op.
- Writes in CLEAR: dropped silently. They must not corrupt the sweep.
- Reads in IDLE: return mem[rd_addr_i].
  - If a write to the same address happens in the same cycle, the read is write-first: enabled lanes return wr_data_i, the other lanes return old contents.
- Reads in CLEAR: accepted. The read data is forced to 0, and rd_valid_o still pulses.
- rd_data_o holds its last value when no read completes. It is never cleared by the sweep itself.
- Memory array is not reset by rst_ni. Only the sweep zeroes it, so it maps to block RAM.

## Timing
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET else IDLE.
  - clr_cnt = 0.
  - busy_o = CLEAR_ON_RESET.
  - rd_data_o = 0.
  - rd_valid_o = 0.
  - all read pipeline registers = 0.
- First sweep write happens on the first rising edge after rst_ni deasserts. busy_o falls after DEPTH edges; the entry at DEPTH-1 is written on that last edge.
- busy_o is a registered output equal to (state == CLEAR).
- Read latency for RD_LATENCY=1: rd_en_i sampled at edge N gives rd_data_o/rd_valid_o valid after edge N. rd_valid_o is high for one cycle per read.
- Read latency for RD_LATENCY=2: valid after edge N+1. The extra stage is a plain output register.
- Full throughput: one read and one write accepted every cycle; back-to-back reads stream with no bubbles.
- Write-to-read at a different cycle: data written at edge N is visible to a read sampled at edge N+1.
- Reset mid-sweep: asynchronous assertion forces all reset values immediately. After release, the sweep restarts at 0 (CLEAR_ON_RESET=1) or the FSM sits in IDLE (CLEAR_ON_RESET=0). In-flight reads are discarded: rd_valid_o = 0.
- Sweep end: clr_i sampled in the final CLEAR cycle is ignored. clr_i in the first IDLE cycle starts a new sweep.

## Test plan
- Reset with defaults -> busy_o = 1 for exactly 256 cycles after release. Afterwards, reading addresses 0, 128 and 255 returns 0x00000000.
- Byte-enable merge -> write 0xAABBCCDD with ben=0xF to addr 5, then 0x11223344 with ben=0x5 to addr 5. A read of addr 5 returns 0xAA22CC44 one cycle after rd_en_i, with rd_valid_o high for one cycle.
- Same-cycle read/write -> addr 7 holds 0x12345678. Write 0x0000BEEF with ben=0x3 while reading addr 7 -> rd_data_o = 0x1234BEEF.
- Clear request -> fill addr 0..3, pulse clr_i -> busy_o high for 256 cycles.
  - A write of 0xFFFFFFFF to addr 2 during the sweep is dropped.
  - Reads during the sweep return 0.
  - After the sweep, addr 0..3 read 0.
- RD_LATENCY=2 -> reads of addr 1,2,3 on consecutive cycles yield rd_valid_o on cycles +2,+3,+4 with the matching data, no gaps.
- Reset mid-sweep -> assert rst_ni low at clr_cnt = 100 -> busy_o and rd_valid_o drop to reset values without waiting for an edge. After release, the sweep runs a full 256 cycles from address 0.
